// File: rtl/force_pkt_arbiter.sv
// ----------------------------------------------------------------------------
// force_pkt_pkg / force_pkt_arbiter
//
// Purpose:
//   Round-robin arbiter that collects force writebacks from NUM_REQ requesters
//   and turns each one into a network packet addressed to the node that owns
//   the particle's cell. Requests carrying an out-of-range cell ID are
//   consumed and counted instead of being forwarded. The output is a single
//   registered stage, so a packet appears one cycle after its request is
//   accepted. The stage can accept a new packet every cycle while downstream
//   keeps pkt_ready high.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   [NUM_REQ]            per-requester valid
//   req_data    in   [NUM_REQ] force_wb_t per-requester force writeback
//   req_ready   out  [NUM_REQ]            per-requester accept (one-hot or 0)
//   pkt_valid   out                       output packet valid
//   pkt_data    out  packet_t             output network packet
//   pkt_ready   in                        downstream accept
//   drop_count  out  [DROP_CNT_WIDTH]     saturating count of dropped requests
// ----------------------------------------------------------------------------
package force_pkt_pkg;

  localparam int NUM_FILTER        = 7;
  localparam int X_DIM             = 4;
  localparam int Y_DIM             = 4;
  localparam int Z_DIM             = 4;
  localparam int CELL_ID_WIDTH     = 3;
  localparam int PARTICLE_ID_WIDTH = 8;
  localparam int FORCE_WIDTH       = 32;
  localparam int NODE_ID_WIDTH     = 6;

  typedef struct packed {
    logic [CELL_ID_WIDTH-1:0]     cell_id_x;
    logic [CELL_ID_WIDTH-1:0]     cell_id_y;
    logic [CELL_ID_WIDTH-1:0]     cell_id_z;
    logic [PARTICLE_ID_WIDTH-1:0] particle_id;
  } particle_ref_t;

  typedef struct packed {
    particle_ref_t          id;
    logic [FORCE_WIDTH-1:0] force_val;
  } force_wb_t;

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] particle_id;
    logic [FORCE_WIDTH-1:0]       force_val;
  } payload_t;

  typedef struct packed {
    logic [NODE_ID_WIDTH-1:0] dest_id;
    payload_t                 payload;
  } packet_t;

endpackage

module force_pkt_arbiter
  import force_pkt_pkg::*;
#(
  parameter int NUM_REQ        = NUM_FILTER,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  force_wb_t [NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      pkt_valid,
  output packet_t                   pkt_data,
  input  logic                      pkt_ready,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          grant_idx;
  logic [PTR_W-1:0]          cand_idx;
  logic [NUM_REQ-1:0]        grant;
  logic                      found;
  int                        cand;
  logic                      load_en;
  logic                      xfer;
  logic                      cell_ok;
  force_wb_t                 sel;
  packet_t                   next_pkt;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  // Round-robin search starting just after the last winner and wrapping, so
  // the last winner itself is considered only after everyone else. The grant
  // follows req_valid combinationally, so a requester that withdraws hands
  // the grant to the next valid one within the same cycle.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(rr_ptr) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = PTR_W'(cand);
      if (!found && req_valid[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  // The output register can take a new packet when it is empty or being
  // drained this cycle. req_ready is additionally gated by rst_n so that
  // nothing is accepted while the block is held in reset.
  assign load_en   = !pkt_valid || pkt_ready;
  assign req_ready = grant & {NUM_REQ{load_en & rst_n}};
  assign xfer      = |req_ready;
  assign sel       = req_data[grant_idx];

  // Cell IDs are 1-based; zero or anything past the grid edge is unroutable.
  // The node ID is the linearised (x,y,z) position with x varying fastest.
  always_comb begin
    cell_ok = (sel.id.cell_id_x != '0) && (sel.id.cell_id_x <= CELL_ID_WIDTH'(X_DIM)) &&
              (sel.id.cell_id_y != '0) && (sel.id.cell_id_y <= CELL_ID_WIDTH'(Y_DIM)) &&
              (sel.id.cell_id_z != '0) && (sel.id.cell_id_z <= CELL_ID_WIDTH'(Z_DIM));
    next_pkt = '0;
    next_pkt.dest_id = NODE_ID_WIDTH'((int'(sel.id.cell_id_z) - 1) * (Y_DIM * X_DIM) +
                                      (int'(sel.id.cell_id_y) - 1) * X_DIM +
                                      (int'(sel.id.cell_id_x) - 1));
    next_pkt.payload.particle_id = sel.id.particle_id;
    next_pkt.payload.force_val   = sel.force_val;
  end

  // Remember the most recent winner. Resetting to the last index makes
  // requester 0 the first one searched after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PTR_W'(NUM_REQ - 1);
    end else if (xfer) begin
      rr_ptr <= grant_idx;
    end
  end

  // Single output stage. When it is allowed to load, it either takes the
  // new packet or goes empty. pkt_data is left untouched when going empty so
  // the last packet stays visible. Dropped requests also leave it empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
    end else if (load_en) begin
      if (xfer && cell_ok) begin
        pkt_valid <= 1'b1;
        pkt_data  <= next_pkt;
      end else begin
        pkt_valid <= 1'b0;
      end
    end
  end

  // Count requests swallowed for an unroutable cell ID, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (xfer && !cell_ok && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_force_pkt_arbiter.sv
// ----------------------------------------------------------------------------
// tb_force_pkt_arbiter
//
// Purpose:
//   Directed bench for force_pkt_arbiter with the default 7 requesters and a
//   16-bit drop counter. Every requester carries a fixed writeback whose
//   destination node ID was worked out by hand and stored in a table.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_force_pkt_arbiter;
  import force_pkt_pkg::*;

  localparam int N = 7;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  force_wb_t [N-1:0]  req_data;
  logic [N-1:0]       req_ready;
  logic               pkt_valid;
  packet_t            pkt_data;
  logic               pkt_ready;
  logic [15:0]        drop_count;

  int checks   = 0;
  int failures = 0;
  int g;

  logic [2:0]  cx       [N] = '{3'd1, 3'd4, 3'd1, 3'd2, 3'd4, 3'd1, 3'd3};
  logic [2:0]  cy       [N] = '{3'd1, 3'd1, 3'd4, 3'd3, 3'd4, 3'd1, 3'd2};
  logic [2:0]  cz       [N] = '{3'd1, 3'd1, 3'd1, 3'd4, 3'd4, 3'd2, 3'd1};
  logic [5:0]  exp_dest [N] = '{6'd0, 6'd3, 6'd12, 6'd57, 6'd63, 6'd16, 6'd6};
  logic [7:0]  pid      [N] = '{8'h10, 8'h11, 8'h12, 8'h05, 8'h14, 8'h15, 8'h16};
  logic [31:0] fval     [N] = '{32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 32'hDEAD_BEEF,
                                32'hF000_0004, 32'hF000_0005, 32'hF000_0006};

  force_pkt_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_ready  (pkt_ready),
    .drop_count (drop_count)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic force_wb_t make_wb(input logic [2:0] x, input logic [2:0] y,
                                        input logic [2:0] z, input logic [7:0] p,
                                        input logic [31:0] f);
    force_wb_t w;
    w.id.cell_id_x   = x;
    w.id.cell_id_y   = y;
    w.id.cell_id_z   = z;
    w.id.particle_id = p;
    w.force_val      = f;
    return w;
  endfunction

  function automatic packet_t exp_pkt(input int i);
    packet_t p;
    p.dest_id             = exp_dest[i];
    p.payload.particle_id = pid[i];
    p.payload.force_val   = fval[i];
    return p;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] v, input logic r);
    req_valid = v;
    pkt_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Safety net so the run always ends even if the clock stops advancing.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence: reset, round-robin sweep, stall, idle, withdrawal,
  // invalid-ID drops with saturation, async reset mid-stall, single requester.
  initial begin
    rst_n = 1'b0;
    applyStimulus('0, 1'b0);
    for (int i = 0; i < N; i++) begin
      req_data[i] = make_wb(cx[i], cy[i], cz[i], pid[i], fval[i]);
    end
    repeat (2) @(posedge clk);
    #1;
    applyStimulus('1, 1'b1);
    #1;
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    checkOutput("rst_pkt_data", 64'(pkt_data), 64'd0);
    checkOutput("rst_drop_count", 64'(drop_count), 64'd0);

    @(negedge clk) rst_n = 1'b1;
    #1;
    checkOutput("first_grant", 64'(req_ready), 64'h01);
    checkOutput("pre_pkt_valid", 64'(pkt_valid), 64'd0);

    for (int k = 0; k < 10; k++) begin
      g = k % N;
      checkOutput("rr_grant", 64'(req_ready), 64'(1) << g);
      @(posedge clk);
      #1;
      checkOutput("rr_pkt_valid", 64'(pkt_valid), 64'd1);
      checkOutput("rr_pkt_data", 64'(pkt_data), 64'(exp_pkt(g)));
    end

    applyStimulus('1, 1'b0);
    #1;
    for (int s = 0; s < 5; s++) begin
      checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("stall_pkt_valid", 64'(pkt_valid), 64'd1);
      checkOutput("stall_pkt_data", 64'(pkt_data), 64'(exp_pkt(2)));
    end
    applyStimulus('1, 1'b1);
    #1;
    checkOutput("release_grant", 64'(req_ready), 64'h08);
    @(posedge clk);
    #1;
    checkOutput("cell_pkt_valid", 64'(pkt_valid), 64'd1);
    checkOutput("cell_dest_id", 64'(pkt_data.dest_id), 64'd57);
    checkOutput("cell_particle_id", 64'(pkt_data.payload.particle_id), 64'd5);
    checkOutput("cell_force_val", 64'(pkt_data.payload.force_val), 64'hDEAD_BEEF);

    applyStimulus('0, 1'b1);
    #1;
    checkOutput("idle_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("idle_pkt_valid", 64'(pkt_valid), 64'd0);
    checkOutput("idle_pkt_hold", 64'(pkt_data), 64'(exp_pkt(3)));

    applyStimulus(7'b0100100, 1'b1);
    #1;
    checkOutput("withdraw_before", 64'(req_ready), 64'h20);
    applyStimulus(7'b0000100, 1'b1);
    #1;
    checkOutput("withdraw_after", 64'(req_ready), 64'h04);
    @(posedge clk);
    #1;
    checkOutput("withdraw_pkt", 64'(pkt_data), 64'(exp_pkt(2)));

    req_data[1] = make_wb(3'd0, 3'd1, 3'd1, 8'hA1, 32'h0000_0001);
    applyStimulus(7'b0000010, 1'b1);
    #1;
    checkOutput("drop_x_grant", 64'(req_ready), 64'h02);
    @(posedge clk);
    #1;
    checkOutput("drop_x_pkt_valid", 64'(pkt_valid), 64'd0);
    checkOutput("drop_x_count", 64'(drop_count), 64'd1);
    req_data[1] = make_wb(3'd1, 3'd5, 3'd1, 8'hA2, 32'h0000_0002);
    #1;
    checkOutput("drop_y_grant", 64'(req_ready), 64'h02);
    @(posedge clk);
    #1;
    checkOutput("drop_y_pkt_valid", 64'(pkt_valid), 64'd0);
    checkOutput("drop_y_count", 64'(drop_count), 64'd2);

    applyStimulus('0, 1'b1);
    force dut.drop_cnt_q = 16'hFFFF;
    release dut.drop_cnt_q;
    req_data[1] = make_wb(3'd1, 3'd1, 3'd0, 8'hA3, 32'h0000_0003);
    applyStimulus(7'b0000010, 1'b1);
    #1;
    @(posedge clk);
    #1;
    checkOutput("drop_sat_count", 64'(drop_count), 64'hFFFF);
    checkOutput("drop_sat_pkt_valid", 64'(pkt_valid), 64'd0);
    req_data[1] = make_wb(cx[1], cy[1], cz[1], pid[1], fval[1]);

    applyStimulus(7'b0010000, 1'b0);
    #1;
    checkOutput("hold_grant", 64'(req_ready), 64'h10);
    @(posedge clk);
    #1;
    checkOutput("hold_pkt_valid", 64'(pkt_valid), 64'd1);
    checkOutput("hold_pkt_data", 64'(pkt_data), 64'(exp_pkt(4)));
    applyStimulus('1, 1'b0);
    #1;
    checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_pkt_valid", 64'(pkt_valid), 64'd0);
    checkOutput("async_pkt_data", 64'(pkt_data), 64'd0);
    checkOutput("async_drop_count", 64'(drop_count), 64'd0);
    checkOutput("async_req_ready", 64'(req_ready), 64'd0);
    applyStimulus(7'b1000001, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    #1;
    checkOutput("post_rst_grant", 64'(req_ready), 64'h01);
    @(posedge clk);
    #1;
    checkOutput("post_rst_pkt", 64'(pkt_data), 64'(exp_pkt(0)));

    applyStimulus(7'b1000000, 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("solo_grant", 64'(req_ready), 64'h40);
      @(posedge clk);
      #1;
      checkOutput("solo_pkt_valid", 64'(pkt_valid), 64'd1);
      checkOutput("solo_pkt_data", 64'(pkt_data), 64'(exp_pkt(6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
